boss_damage_ctrl: RTL and testbench

- Consumes the per-pixel melee_hit strobe from the weapon drawing stage and an arrow_hit strobe from the projectile stage.
- Integrates hits once per video frame and applies damage to the boss HP counter, with invulnerability frames after each accepted hit.
- Drives boss_alive back to the weapon drawing stage and the boss renderer, plus a hit-flash flag for the boss sprite.
- Sits in the VGA pixel-clock domain, downstream of weapon drawing and in parallel with the boss draw stage.

---
 rtl/game_pkg.sv | 21 ++
 rtl/frame_tick_gen.sv | 22 ++
 rtl/boss_damage_ctrl.sv | 161 ++++++++++++++++
 tb/tb_boss_damage_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level types and default tuning constants for per-frame controllers.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIGHT  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } boss_state_t;

  localparam int BOSS_MAX_HP_DEF  = 100;
  localparam int MELEE_DMG_DEF    = 5;
  localparam int ARCHER_DMG_DEF   = 2;
  localparam int IFRAMES_DEF      = 30;
  localparam int FLASH_FRAMES_DEF = 8;

  // Boss sprite footprint, shared with the weapon and boss draw stages
  localparam int BOSS_LNG = 64;
  localparam int BOSS_HGT = 64;

endpackage

// File: rtl/frame_tick_gen.sv
// End-of-frame pulse from the rising edge of vertical blank.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vblnk,
  output logic frame_end
);

  logic vblnk_q, vblnk_d;

  // next value of the delayed vblank
  always_comb vblnk_d = vblnk;

  // one-cycle delay of vblank for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vblnk_q <= 1'b0;
    else        vblnk_q <= vblnk_d;
  end

  assign frame_end = vblnk & ~vblnk_q;

endmodule

// File: rtl/boss_damage_ctrl.sv
// Boss HP controller: integrates melee/arrow hits per frame, applies damage,
// holds invulnerability frames and drives the hit-flash request.
//
//   state  | meaning
//   IDLE   | no fight; HP parked at max
//   FIGHT  | boss vulnerable; damage applied at frame end
//   INVULN | post-hit invulnerability; hits discarded
//   DEAD   | HP reached zero; waits for the fight to end
module boss_damage_ctrl
  import game_pkg::*;
#(
  parameter int BOSS_MAX_HP  = BOSS_MAX_HP_DEF,
  parameter int MELEE_DMG    = MELEE_DMG_DEF,
  parameter int ARCHER_DMG   = ARCHER_DMG_DEF,
  parameter int IFRAMES      = IFRAMES_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter int HP_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vblnk,
  input  logic [1:0]      game_active,
  input  logic            melee_hit,
  input  logic            arrow_hit,
  output logic [HP_W-1:0] boss_hp,
  output logic            boss_alive,
  output logic            boss_flash,
  output logic            boss_defeated
);

  // iframe counter holds IFRAMES-1 at most; flash counter holds FLASH_FRAMES
  localparam int IF_W = (IFRAMES > 2) ? $clog2(IFRAMES) : 1;
  localparam int FL_W = $clog2(FLASH_FRAMES + 1);

  localparam logic [HP_W-1:0] HP_MAX   = HP_W'(BOSS_MAX_HP);
  localparam logic [HP_W:0]   MELEE_V  = (HP_W+1)'(MELEE_DMG);
  localparam logic [HP_W:0]   ARCHER_V = (HP_W+1)'(ARCHER_DMG);

  logic frame_end;

  frame_tick_gen u_frame_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk     (vblnk),
    .frame_end (frame_end)
  );

  boss_state_t     state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [IF_W-1:0] iframe_q, iframe_d;
  logic [FL_W-1:0] flash_cnt_q, flash_cnt_d;
  logic            melee_seen_q, melee_seen_d;
  logic            arrow_seen_q, arrow_seen_d;
  logic            alive_q, alive_d;
  logic            flash_q, flash_d;
  logic            defeated_q, defeated_d;
  logic [HP_W:0]   dmg;
  logic            fight_on;

  assign fight_on = |game_active;

  // hit flags: latch strobes during active video, clear at each frame end
  always_comb begin
    melee_seen_d = melee_seen_q | (melee_hit & ~vblnk);
    arrow_seen_d = arrow_seen_q | (arrow_hit & ~vblnk);
    if (frame_end) begin
      melee_seen_d = 1'b0;
      arrow_seen_d = 1'b0;
    end
  end

  // damage of the frame being closed; melee and arrow add up
  always_comb begin
    dmg = (melee_seen_q ? MELEE_V : '0) + (arrow_seen_q ? ARCHER_V : '0);
  end

  // next-state, HP, counters and registered output values
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    iframe_d    = iframe_q;
    defeated_d  = 1'b0;
    flash_cnt_d = (frame_end && flash_cnt_q != '0) ? flash_cnt_q - FL_W'(1) : flash_cnt_q;

    case (state_q)
      IDLE: begin
        hp_d        = HP_MAX;
        iframe_d    = '0;
        flash_cnt_d = '0;
        if (fight_on) state_d = FIGHT;
      end
      FIGHT: begin
        if (frame_end && dmg != '0) begin
          if ({1'b0, hp_q} <= dmg) begin
            hp_d       = '0;
            defeated_d = 1'b1;
            state_d    = DEAD;
          end else begin
            hp_d        = hp_q - dmg[HP_W-1:0];
            iframe_d    = IF_W'(IFRAMES - 1);
            flash_cnt_d = FL_W'(FLASH_FRAMES);
            state_d     = INVULN;
          end
        end
      end
      INVULN: begin
        if (frame_end) begin
          if (iframe_q == '0) state_d = FIGHT;
          else                iframe_d = iframe_q - IF_W'(1);
        end
      end
      DEAD: begin
        hp_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // leaving the fight wins over any same-cycle frame update
    if (state_q != IDLE && !fight_on) begin
      state_d     = IDLE;
      hp_d        = HP_MAX;
      iframe_d    = '0;
      flash_cnt_d = '0;
      defeated_d  = 1'b0;
    end

    alive_d = (state_d == FIGHT) || (state_d == INVULN);
    flash_d = (flash_cnt_d != '0);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hp_q         <= HP_MAX;
      iframe_q     <= '0;
      flash_cnt_q  <= '0;
      melee_seen_q <= 1'b0;
      arrow_seen_q <= 1'b0;
      alive_q      <= 1'b0;
      flash_q      <= 1'b0;
      defeated_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_q         <= hp_d;
      iframe_q     <= iframe_d;
      flash_cnt_q  <= flash_cnt_d;
      melee_seen_q <= melee_seen_d;
      arrow_seen_q <= arrow_seen_d;
      alive_q      <= alive_d;
      flash_q      <= flash_d;
      defeated_q   <= defeated_d;
    end
  end

  assign boss_hp       = hp_q;
  assign boss_alive    = alive_q;
  assign boss_flash    = flash_q;
  assign boss_defeated = defeated_q;

endmodule

// File: tb/tb_boss_damage_ctrl.sv
// Directed bench for boss_damage_ctrl with a frame-level reference model.
module tb_boss_damage_ctrl;

  localparam int MAX_HP = 100;
  localparam int MEL    = 5;
  localparam int ARR    = 2;
  localparam int IFR    = 30;
  localparam int FL     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vblnk = 1'b0;
  logic [1:0] game_active = 2'd0;
  logic       melee_hit = 1'b0;
  logic       arrow_hit = 1'b0;
  logic [7:0] boss_hp;
  logic       boss_alive, boss_flash, boss_defeated;

  int checks = 0;
  int errors = 0;
  int def_pulses = 0;
  int flash_obs = 0;

  boss_damage_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vblnk         (vblnk),
    .game_active   (game_active),
    .melee_hit     (melee_hit),
    .arrow_hit     (arrow_hit),
    .boss_hp       (boss_hp),
    .boss_alive    (boss_alive),
    .boss_flash    (boss_flash),
    .boss_defeated (boss_defeated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in game terms: fight mode, hit points, frames of
  // remaining immunity and remaining flash frames.
  int m_mode;        // 0 no fight, 1 fighting, 2 defeated
  int m_hp, m_ignore, m_flash, m_dmg;
  bit m_def, m_melee, m_arrow, m_vb, m_fe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_hp = MAX_HP; m_ignore = 0; m_flash = 0;
      m_def = 0; m_melee = 0; m_arrow = 0; m_vb = 0;
    end else begin
      m_fe  = vblnk && !m_vb;
      m_vb  = vblnk;
      m_dmg = (m_melee ? MEL : 0) + (m_arrow ? ARR : 0);
      m_def = 0;
      if (m_mode == 0) begin
        m_hp = MAX_HP; m_ignore = 0; m_flash = 0;
        if (game_active != 0) m_mode = 1;
      end else if (game_active == 0) begin
        m_mode = 0; m_hp = MAX_HP; m_ignore = 0; m_flash = 0;
      end else if (m_fe) begin
        if (m_flash > 0) m_flash--;
        if (m_mode == 1) begin
          if (m_ignore > 0) m_ignore--;
          else if (m_dmg > 0) begin
            if (m_hp <= m_dmg) begin
              m_hp = 0; m_mode = 2; m_def = 1;
            end else begin
              m_hp = m_hp - m_dmg; m_ignore = IFR; m_flash = FL;
            end
          end
        end
      end
      if (m_fe) begin
        m_melee = 0; m_arrow = 0;
      end else if (!vblnk) begin
        if (melee_hit) m_melee = 1;
        if (arrow_hit) m_arrow = 1;
      end
    end
  end

  // per-cycle comparison against the model, just after each active edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("cyc_hp", int'(boss_hp), m_hp);
      chk("cyc_alive", int'(boss_alive), (m_mode == 1) ? 1 : 0);
      chk("cyc_flash", int'(boss_flash), (m_flash != 0) ? 1 : 0);
      chk("cyc_defeated", int'(boss_defeated), int'(m_def));
      if (boss_defeated) def_pulses++;
    end
  end

  // one video frame: act active cycles with strobe pulses, then 3 blank cycles
  task automatic run_frame(input int act, input int mel, input int arr, input bit vbl_hit);
    for (int i = 0; i < act; i++) begin
      @(negedge clk);
      vblnk     = 1'b0;
      melee_hit = (i % 2 == 0) && (i / 2 < mel);
      arrow_hit = (i % 2 == 1) && (i / 2 < arr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vblnk     = 1'b1;
      melee_hit = vbl_hit;
      arrow_hit = vbl_hit;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hp", int'(boss_hp), 100);
    chk("rst_alive", int'(boss_alive), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hp", int'(boss_hp), 100);
    chk("idle_alive", int'(boss_alive), 0);

    game_active = 2'd1;
    @(negedge clk);
    chk("start_alive", int'(boss_alive), 1);
    chk("start_hp", int'(boss_hp), 100);
    chk("start_flash", int'(boss_flash), 0);
    chk("start_defeated", int'(boss_defeated), 0);

    // strobes during vertical blank do not count
    run_frame(8, 0, 0, 1'b1);
    chk("vblank_hit_hp", int'(boss_hp), 100);

    // 40 melee pulses in one frame: single damage
    run_frame(80, 40, 0, 1'b0);
    chk("first_hit_hp", int'(boss_hp), 95);
    chk("first_hit_flash", int'(boss_flash), 1);
    if (boss_flash) flash_obs++;

    // frames 2..31 ignored; flash seen at the end of 8 frames in total
    for (int f = 0; f < 30; f++) begin
      run_frame(8, 4, 0, 1'b0);
      if (boss_flash) flash_obs++;
    end
    chk("iframes_hp", int'(boss_hp), 95);
    chk("flash_frames", flash_obs, 8);
    chk("flash_off", int'(boss_flash), 0);

    run_frame(8, 4, 0, 1'b0);
    chk("frame32_hp", int'(boss_hp), 90);

    // 12 combined hits of 7 each: 90 -> 6
    for (int h = 0; h < 12; h++) begin
      repeat (30) run_frame(6, 0, 0, 1'b0);
      run_frame(6, 1, 1, 1'b0);
    end
    chk("combo_hp", int'(boss_hp), 6);

    // 7 damage against 6 HP saturates to 0
    repeat (30) run_frame(6, 0, 0, 1'b0);
    run_frame(6, 1, 1, 1'b0);
    chk("kill_hp", int'(boss_hp), 0);
    chk("kill_alive", int'(boss_alive), 0);
    chk("kill_pulses", def_pulses, 1);
    repeat (3) run_frame(6, 1, 1, 1'b0);
    chk("dead_hp", int'(boss_hp), 0);
    chk("dead_pulses", def_pulses, 1);

    game_active = 2'd0;
    @(negedge clk);
    chk("end_hp", int'(boss_hp), 100);
    chk("end_alive", int'(boss_alive), 0);

    // new fight, then drop game_active exactly on a frame_end cycle
    game_active = 2'd3;
    @(negedge clk);
    chk("refight_alive", int'(boss_alive), 1);
    run_frame(6, 1, 0, 1'b0);
    chk("refight_hp", int'(boss_hp), 95);
    repeat (2) run_frame(6, 0, 0, 1'b0);
    chk("pre_drop_flash", int'(boss_flash), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vblnk = 1'b0; melee_hit = 1'b0; arrow_hit = 1'b0;
    end
    @(negedge clk);
    vblnk = 1'b1;
    game_active = 2'd0;
    @(negedge clk);
    chk("drop_hp", int'(boss_hp), 100);
    chk("drop_flash", int'(boss_flash), 0);
    chk("drop_alive", int'(boss_alive), 0);
    @(negedge clk);

    // asynchronous reset between clock edges mid-fight
    game_active = 2'd1;
    @(negedge clk);
    run_frame(6, 1, 0, 1'b0);
    chk("prerst_hp", int'(boss_hp), 95);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_hp", int'(boss_hp), 100);
    chk("arst_alive", int'(boss_alive), 0);
    chk("arst_flash", int'(boss_flash), 0);
    chk("arst_defeated", int'(boss_defeated), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_alive", int'(boss_alive), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
